// File: rtl/sync_fifo_flex.sv
// rtl/sync_fifo_flex.sv - parametrised single-clock FIFO with occupancy, thresholds, error pulses and FWFT option
//
// Purpose: general buffering stage between producer and consumer logic in one clock domain.
// Ports:
//   clk          - clock, all state on rising edge
//   rst_n        - asynchronous active-low reset
//   wr_en, din   - write request and write data
//   rd_en        - read request (pop)
//   dout         - read data (registered in standard mode, head word in FWFT mode)
//   rd_valid     - newly popped data pulse (standard) / head word present (FWFT)
//   full, empty, almost_full, almost_empty - flags decoded from count
//   count        - current occupancy, 0..DEPTH
//   overflow     - one-cycle pulse for a rejected write
//   underflow    - one-cycle pulse for a rejected read
module sync_fifo_flex #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 2,
  parameter int FWFT       = 0,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = CW'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C    = CW'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_C    = CW'(AE_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  wr_acc;
  logic                  rd_acc;

  // Flags come from the occupancy counter only; pointers are allowed to alias.
  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  // Acceptance is judged on pre-edge state, so a full FIFO can still pop and
  // an empty one can still push in the same cycle (no write-to-read bypass).
  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  // Storage has no reset; stale words are unreachable once pointers/count clear.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= wr_en & full;
      underflow <= rd_en & empty;
      if (wr_acc) begin
        wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is shown directly; forced to zero while empty so reset
      // presents a clean dout.
      assign dout     = empty ? '0 : mem[rd_ptr];
      assign rd_valid = ~empty;
    end else begin : g_std
      logic [DATA_WIDTH-1:0] dout_q;
      logic                  rd_valid_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dout_q     <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          rd_valid_q <= rd_acc;
          if (rd_acc) begin
            dout_q <= mem[rd_ptr];
          end
        end
      end

      assign dout     = dout_q;
      assign rd_valid = rd_valid_q;
    end
  endgenerate

endmodule

// File: doc/sync_fifo_flex.md
Name:
sync_fifo_flex

Overview:
Parametrised single-clock FIFO, the successor to the team's basic sync FIFO. Adds occupancy count, programmable almost-full/almost-empty thresholds, overflow/underflow error pulses, a read-valid strobe and a selectable first-word-fall-through (FWFT) read mode. Used as a general buffering stage between producer and consumer logic in the same clock domain.

Parameters:
DATA_WIDTH, 8, data word width in bits
DEPTH, 8, number of entries; power of 2, >= 2
AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH; legal range 1..DEPTH
AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH; legal range 0..DEPTH-1
FWFT, 0, 0 = standard registered read (1-cycle latency); 1 = first-word-fall-through
ADDR_WIDTH, $clog2(DEPTH), derived pointer width; not overridden

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
wr_en  input  1  write request
din  input  DATA_WIDTH  write data
rd_en  input  1  read request (pop)
dout  output  DATA_WIDTH  read data
rd_valid  output  1  dout holds newly popped data (std) / head word present (FWFT)
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_THRESH
almost_empty  output  1  count <= AE_THRESH
count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH
overflow  output  1  one-cycle pulse: write request rejected
underflow  output  1  one-cycle pulse: read request rejected

Behaviour:
- Reset (rst_n low, async assert, sync release on next clk edge): wr_ptr=rd_ptr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, dout=0, rd_valid=0, overflow=0, underflow=0. Memory contents not reset. Reset mid-operation discards all stored data.
- Pointers ADDR_WIDTH bits, wrap DEPTH-1 -> 0 naturally; full/empty derived from count, never from pointer compare.
- wr_acc = wr_en & ~full; rd_acc = rd_en & ~empty. Evaluated on pre-edge state.
- wr_acc: mem[wr_ptr] <= din, wr_ptr+1. rd_acc: rd_ptr+1.
- count: +1 on wr_acc only, -1 on rd_acc only, unchanged when both or neither.
- Full with wr_en & rd_en: read accepted, write rejected, overflow pulses, count -> DEPTH-1.
- Empty with wr_en & rd_en: write accepted, read rejected, underflow pulses, count -> 1. No bypass of write data to dout.
- overflow <= wr_en & full; underflow <= rd_en & empty; registered, high exactly one cycle per rejected request.
- All flags are combinational from registered count; they change in the same cycle as count.
- Standard mode (FWFT=0): on rd_acc, dout <= mem[rd_ptr] at that edge; rd_valid <= rd_acc (one-cycle pulse). dout holds last value otherwise.
- FWFT mode (FWFT=1): dout = mem[rd_ptr] combinationally whenever !empty; rd_valid = ~empty; rd_en pops the displayed word. dout is don't-care while empty. First written word appears on dout the cycle after its write edge.
- Order preserved across any number of wraps.

Test Plan:
- Reset, then write 10..17 on 8 consecutive cycles (DEPTH=8) -> count 1..8, almost_full rises at count=6, full=1 after 8th write, empty=0 after 1st, almost_empty falls at count=3.
- At full, wr_en=1 din=99 one cycle -> overflow single pulse, count stays 8; then read 8 (FWFT=0) -> dout 10..17 each one cycle after rd_en with rd_valid pulse; 99 never appears; empty=1 at end.
- At empty, rd_en=1 one cycle -> underflow single pulse, count 0, dout keeps 17, rd_valid=0.
- Count=3, wr_en=rd_en=1 for 4 cycles writing 20..23 -> count stays 3, dout outputs oldest three then 20; full-with-both case -> count 7, overflow pulse; empty-with-both case -> count 1, underflow pulse.
- Wrap: write 5/read 5 repeated 3 times with values 0..14 -> output sequence 0..14 in order, pointers wrap without loss.
- FWFT=1: write 42 -> next cycle dout=42, rd_valid=1 without rd_en; rd_en pops -> empty=1, rd_valid=0. Assert rst_n low mid-fill at count=5 -> all outputs reset values immediately, count=0.
